// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode encoding and response-register states.
package alu_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9
  } alu_op_e;

  localparam logic [ALU_OP_W-1:0] ALU_OP_LAST = 4'd9;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } resp_state_e;

  function automatic logic op_is_illegal(input logic [ALU_OP_W-1:0] op);
    return op > ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/alu_rr_grant.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module alu_rr_grant #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx
);

  int unsigned     w_idx;
  logic [ID_W-1:0] w_sel;
  logic            w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_idx       = 0;
    w_sel       = '0;
    w_found     = 1'b0;
    if (i_enable) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        w_idx = (32'(i_rr_ptr) + off) % NUM_REQ;
        w_sel = w_idx[ID_W-1:0];
        if (!w_found && i_req[w_sel]) begin
          w_found        = 1'b1;
          o_grant[w_sel] = 1'b1;
          o_grant_idx    = w_sel;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_alu.sv
// Combinational RISC-V style ALU; subtract, compares and shifts take operand_b as the
// primary operand and operand_a as the subtrahend / compare reference / shift amount.
module riscv_alu
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] i_op,
  input  logic [XLEN-1:0]     i_operand_a,
  input  logic [XLEN-1:0]     i_operand_b,
  output logic [XLEN-1:0]     o_result,
  output logic                o_zero,
  output logic                o_illegal
);

  alu_op_e    w_op;
  logic [4:0] w_shamt;
  logic       w_lt_s;
  logic       w_lt_u;

  assign w_op    = alu_op_e'(i_op);
  assign w_shamt = i_operand_a[4:0];
  assign w_lt_s  = $signed(i_operand_b) < $signed(i_operand_a);
  assign w_lt_u  = i_operand_b < i_operand_a;

  always_comb begin
    o_result = '0;
    case (w_op)
      ADD:     o_result = i_operand_b + i_operand_a;
      SUB:     o_result = i_operand_b - i_operand_a;
      AND:     o_result = i_operand_b & i_operand_a;
      OR:      o_result = i_operand_b | i_operand_a;
      XOR:     o_result = i_operand_b ^ i_operand_a;
      SLT:     o_result = {{(XLEN-1){1'b0}}, w_lt_s};
      SLTU:    o_result = {{(XLEN-1){1'b0}}, w_lt_u};
      SLL:     o_result = i_operand_b << w_shamt;
      SRL:     o_result = i_operand_b >> w_shamt;
      SRA:     o_result = $unsigned($signed(i_operand_b) >>> w_shamt);
      default: o_result = '0;
    endcase
  end

  // Illegal opcodes fall through to a zero result, so the zero flag reads 1 for them.
  assign o_illegal = op_is_illegal(i_op);
  assign o_zero    = (o_result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one riscv_alu between NUM_REQ requesters via round-robin arbitration and a
// single registered response drained over a valid/ready channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
  input  logic [NUM_REQ*XLEN-1:0]     req_a,
  input  logic [NUM_REQ*XLEN-1:0]     req_b,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_W-1:0]             resp_id,
  output logic [XLEN-1:0]             resp_result,
  output logic                        resp_zero,
  output logic                        resp_err
);

  resp_state_e r_state;
  resp_state_e w_state_nxt;

  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [XLEN-1:0]     r_result;
  logic                r_zero;
  logic                r_err;

  logic                w_can_accept;
  logic                w_accept;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gidx;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [ALU_OP_W-1:0] w_op;
  logic [XLEN-1:0]     w_a;
  logic [XLEN-1:0]     w_b;
  logic [XLEN-1:0]     w_result;
  logic                w_zero;
  logic                w_illegal;

  // A full register may take a new result only in the cycle it is being drained.
  assign w_can_accept = (r_state == EMPTY) || resp_ready;

  alu_rr_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_grant (
    .i_req       (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .i_enable    (w_can_accept && rst_n),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign req_ready = w_grant;
  assign w_accept  = |(req_valid & w_grant);

  assign w_op = req_op[w_gidx*ALU_OP_W +: ALU_OP_W];
  assign w_a  = req_a[w_gidx*XLEN +: XLEN];
  assign w_b  = req_b[w_gidx*XLEN +: XLEN];

  riscv_alu u_alu (
    .i_op        (w_op),
    .i_operand_a (w_a),
    .i_operand_b (w_b),
    .o_result    (w_result),
    .o_zero      (w_zero),
    .o_illegal   (w_illegal)
  );

  always_comb begin
    w_ptr_nxt = w_gidx + 1'b1;
    if (32'(w_gidx) == NUM_REQ - 1) begin
      w_ptr_nxt = '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (!w_accept && resp_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rr_ptr <= w_ptr_nxt;
        r_id     <= w_gidx;
        r_result <= w_result;
        r_zero   <= w_zero;
        r_err    <= w_illegal;
      end
    end
  end

  assign resp_valid  = (r_state == FULL);
  assign resp_id     = r_id;
  assign resp_result = r_result;
  assign resp_zero   = r_zero;
  assign resp_err    = r_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a round-robin/ALU reference model predicts
// grants and responses; a monitor compares every presented response.
module tb_alu_share_arbiter;

  localparam int N   = 2;
  localparam int IDW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*4-1:0]  req_op;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [31:0]     resp_result;
  logic            resp_zero;
  logic            resp_err;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: next requester to favour, and whether a response is held.
  int   m_ptr;
  bit   m_full;

  logic [3:0]   p_op[N];
  logic [31:0]  p_a[N];
  logic [31:0]  p_b[N];
  logic [N-1:0] p_valid;
  logic [N-1:0] last_ready;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic e);
    e = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = b - a;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(b) < $signed(a)) ? 32'd1 : 32'd0;
      4'd6: r = (b < a) ? 32'd1 : 32'd0;
      4'd7: r = b << a[4:0];
      4'd8: r = b >> a[4:0];
      4'd9: r = $signed(b) >>> a[4:0];
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic apply();
    req_valid = p_valid;
    for (int i = 0; i < N; i++) begin
      req_op[i*4 +: 4]  = p_op[i];
      req_a[i*32 +: 32] = p_a[i];
      req_b[i*32 +: 32] = p_b[i];
    end
  endtask

  // One clock of the reference model, evaluated mid-cycle once inputs have settled.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int           g;
    exp_t         e;
    @(negedge clk);
    #1;
    last_ready = req_ready;
    if (!rst_n) begin
      chk("req_ready_in_reset", 64'(req_ready), 64'(0));
      m_full = 1'b0;
      m_ptr  = 0;
      sbq.delete();
    end else begin
      chk("resp_valid", 64'(resp_valid), 64'(m_full));
      exp_rdy = '0;
      g       = -1;
      if (!m_full || resp_ready) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (g < 0 && p_valid[i]) g = i;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (g >= 0) begin
        e.id = g;
        ref_alu(p_op[g], p_a[g], p_b[g], e.res, e.zero, e.err);
        sbq.push_back(e);
        m_ptr  = (g + 1) % N;
        m_full = 1'b1;
      end else if (resp_ready) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    p_op[i] = op;
    p_a[i]  = a;
    p_b[i]  = b;
  endtask

  task automatic single(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int budget;
    set_req(i, op, a, b);
    p_valid[i] = 1'b1;
    budget     = 10;
    apply();
    step();
    while (!last_ready[i] && budget > 0) begin
      budget--;
      step();
    end
    if (!last_ready[i]) chk("single_accept_timeout", 64'(0), 64'(1));
    p_valid[i] = 1'b0;
    apply();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(4))
      0:       return 32'($urandom_range(40));
      1:       return 32'h0;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every presented response is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=id%0d/%0h expected=none (t=%0t)", resp_id, resp_result, $time);
        end else begin
          e = sbq[0];
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_result", 64'(resp_result), 64'(e.res));
          chk("resp_zero", 64'(resp_zero), 64'(e.zero));
          chk("resp_err", 64'(resp_err), 64'(e.err));
          if (resp_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_ptr      = 0;
    m_full     = 1'b0;
    p_valid    = '0;
    last_ready = '0;
    for (int i = 0; i < N; i++) set_req(i, 4'd0, 32'd0, 32'd0);
    rst_n      = 1'b0;
    resp_ready = 1'b0;
    apply();
    repeat (2) step();
    rst_n = 1'b1;

    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_resp_result", 64'(resp_result), 64'(0));
    chk("rst_resp_zero", 64'(resp_zero), 64'(0));
    chk("rst_resp_err", 64'(resp_err), 64'(0));

    // Single ADD right after reset.
    resp_ready = 1'b1;
    single(0, 4'd0, 32'd5, 32'd7);
    step();

    // Contention: both requesters continuously valid.
    set_req(0, 4'd1, 32'd3, 32'd3);
    set_req(1, 4'd4, 32'h0000_00FF, 32'h0000_000F);
    p_valid = '1;
    apply();
    repeat (4) step();

    // Backpressure with a held response, then simultaneous drain and accept.
    resp_ready = 1'b0;
    apply();
    repeat (3) step();
    resp_ready = 1'b1;
    step();
    p_valid = '0;
    apply();
    repeat (2) step();

    // Shift and compare semantics.
    single(0, 4'd9, 32'd4, 32'h8000_0000);
    single(0, 4'd6, 32'd1, 32'hFFFF_FFFF);
    single(0, 4'd5, 32'd1, 32'hFFFF_FFFF);
    single(1, 4'd7, 32'd31, 32'h0000_0003);
    single(0, 4'd8, 32'd36, 32'hF000_0000);
    step();

    // Illegal opcode from requester 1, then both valid.
    single(1, 4'hC, 32'd9, 32'd9);
    set_req(0, 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    set_req(1, 4'd3, 32'h1, 32'h2);
    p_valid = '1;
    apply();
    step();
    p_valid = '0;
    apply();
    repeat (2) step();

    // Reset while a response is held.
    resp_ready = 1'b0;
    single(1, 4'd0, 32'd1, 32'd2);
    step();
    rst_n = 1'b0;
    apply();
    step();
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    set_req(0, 4'd0, 32'd10, 32'd20);
    set_req(1, 4'd0, 32'd30, 32'd40);
    p_valid = '1;
    apply();
    step();
    p_valid = '0;
    apply();
    repeat (2) step();

    // Randomized traffic with requester hold obligations honoured.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && $urandom_range(99) < 60) begin
          p_valid[i] = 1'b1;
          set_req(i, 4'($urandom_range(15)), rand_operand(), rand_operand());
        end
      end
      resp_ready = ($urandom_range(99) < 70);
      rst_n      = ($urandom_range(149) != 0);
      apply();
      step();
      for (int i = 0; i < N; i++) if (last_ready[i]) p_valid[i] = 1'b0;
      rst_n = 1'b1;
    end

    p_valid    = '0;
    resp_ready = 1'b1;
    apply();
    repeat (3) step();
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
